// File: rtl/cache_ctrl.sv
// cache_ctrl: two-way set-associative, write-through, no-write-allocate data cache
// between the MEM stage and the SRAM controller. 64 sets, 8-byte lines, 10-bit tag.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_rd_en, cpu_wr_en     load / store request (held while cpu_ready=0)
//   cpu_address, cpu_wdata   byte address (>=1024, word aligned), store data
//   cpu_rdata, cpu_ready     load data (0 unless a completing load), 0 = stall pipeline
//   sram_rd_en, sram_wr_en   line read / word write request to SRAM controller
//   sram_address             cpu_address passed through (controller subtracts 1024)
//   sram_write_data          cpu_wdata passed through
//   sram_read_data           fetched line, [31:0] even word, [63:32] odd word
//   sram_ready               SRAM transaction complete
module cache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e state_q, state_d;

  logic [1:0][63:0] valid_q;
  logic [63:0]      lru_q;          // per set: way to evict next
  logic [9:0]       tag_q  [2][64];
  logic [63:0]      data_q [2][64];

  // Word address relative to the SRAM base; byte offset bits are always zero.
  logic [16:0] mem_word;
  logic        word_sel;
  logic [5:0]  idx;
  logic [9:0]  tag;

  assign mem_word = cpu_address[18:2] - 17'd256;
  assign word_sel = mem_word[0];
  assign idx      = mem_word[6:1];
  assign tag      = mem_word[16:7];

  logic        hit0, hit1, hit, hit_way, victim;
  logic [63:0] hit_line;
  logic [31:0] hit_word, fill_word;

  assign hit0      = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1      = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = hit1;
  assign hit_line  = hit1 ? data_q[1][idx] : data_q[0][idx];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_read_data[63:32] : sram_read_data[31:0];
  assign victim    = lru_q[idx];

  assign sram_address    = cpu_address;
  assign sram_write_data = cpu_wdata;

  logic lru_we, lru_val, fill_we, word_we;

  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b1;
    cpu_rdata  = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    fill_we    = 1'b0;
    word_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A simultaneous load and store takes the store path.
        if (cpu_wr_en) begin
          cpu_ready = 1'b0;
          state_d   = StWrite;
        end else if (cpu_rd_en) begin
          if (hit) begin
            cpu_rdata = hit_word;
            lru_we    = 1'b1;
            lru_val   = ~hit_way;
          end else begin
            cpu_ready = 1'b0;
            state_d   = StRead;
          end
        end
      end
      StRead: begin
        sram_rd_en = 1'b1;
        if (sram_ready) begin
          fill_we   = 1'b1;
          lru_we    = 1'b1;
          lru_val   = ~victim;
          cpu_rdata = fill_word;
          state_d   = StIdle;
        end else begin
          cpu_ready = 1'b0;
        end
      end
      StWrite: begin
        sram_wr_en = 1'b1;
        if (sram_ready) begin
          // Write-through: update a resident copy, never allocate on a store miss.
          if (hit) begin
            word_we = 1'b1;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end
          state_d = StIdle;
        end else begin
          cpu_ready = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      if (fill_we) valid_q[victim][idx] <= 1'b1;
      if (lru_we)  lru_q[idx] <= lru_val;
    end
  end

  // Tag and data arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= sram_read_data;
    end
    if (word_we) begin
      if (word_sel) data_q[hit_way][idx][63:32] <= cpu_wdata;
      else          data_q[hit_way][idx][31:0]  <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en, cpu_wr_en;
  logic [31:0] cpu_address, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;

  cache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_rd_en       (cpu_rd_en),
    .cpu_wr_en       (cpu_wr_en),
    .cpu_address     (cpu_address),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_ready       (cpu_ready),
    .sram_rd_en      (sram_rd_en),
    .sram_wr_en      (sram_wr_en),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .sram_ready      (sram_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory seen through the SRAM controller (word granular).
  logic [31:0] mem [int];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM controller model: completes after lat cycles of asserted request.
  int lat   = 6;
  int cnt   = 0;
  bit noise = 1'b0;

  always @(posedge clk) begin
    #2;
    if (sram_rd_en || sram_wr_en) cnt++;
    else cnt = 0;
    if (sram_rd_en || sram_wr_en) sram_ready = (cnt >= lat);
    else sram_ready = noise && ($urandom_range(0, 3) == 0);
    sram_read_data = {mem_rd((cpu_address & ~32'h7) + 32'd4), mem_rd(cpu_address & ~32'h7)};
  end

  // Behavioural cache model: contents, LRU, and one outstanding SRAM transaction.
  bit          m_valid [2][64];
  logic [9:0]  m_tag   [2][64];
  logic [63:0] m_data  [2][64];
  bit          m_lru   [64];
  int          pending = 0;  // 0 none, 1 line fetch outstanding, 2 store outstanding

  always @(negedge clk) begin
    logic [31:0] ma;
    int          idx;
    logic [9:0]  tg;
    bit          hit, v;
    int          way;
    logic [31:0] e_rdata;
    bit          e_ready, e_rd, e_wr;

    if (rst) begin
      pending = 0;
      for (int s = 0; s < 64; s++) begin
        m_valid[0][s] = 0;
        m_valid[1][s] = 0;
        m_lru[s]      = 0;
      end
    end

    ma  = cpu_address - 32'd1024;
    idx = int'(ma[8:3]);
    tg  = ma[18:9];
    hit = 0;
    way = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tg) begin
        hit = 1;
        way = w;
      end

    e_rdata = '0;
    e_ready = 1;
    e_rd    = (pending == 1);
    e_wr    = (pending == 2);
    if (pending == 0) begin
      if (cpu_wr_en) e_ready = 0;
      else if (cpu_rd_en) begin
        if (hit) e_rdata = m_data[way][idx][ma[2]*32 +: 32];
        else e_ready = 0;
      end
    end else begin
      e_ready = sram_ready;
      if (pending == 1 && sram_ready) e_rdata = sram_read_data[ma[2]*32 +: 32];
    end

    check("cpu_ready", cpu_ready, e_ready);
    check("cpu_rdata", cpu_rdata, e_rdata);
    check("sram_rd_en", sram_rd_en, e_rd);
    check("sram_wr_en", sram_wr_en, e_wr);
    check("sram_address", sram_address, cpu_address);
    check("sram_write_data", sram_write_data, cpu_wdata);

    if (!rst) begin
      if (pending == 0) begin
        if (cpu_wr_en) pending = 2;
        else if (cpu_rd_en) begin
          if (hit) m_lru[idx] = (way == 0);
          else pending = 1;
        end
      end else if (pending == 1 && sram_ready) begin
        v = m_lru[idx];
        m_valid[v][idx] = 1;
        m_tag[v][idx]   = tg;
        m_data[v][idx]  = sram_read_data;
        m_lru[idx]      = !v;
        pending         = 0;
      end else if (pending == 2 && sram_ready) begin
        mem[int'(cpu_address)] = cpu_wdata;
        if (hit) begin
          m_data[way][idx][ma[2]*32 +: 32] = cpu_wdata;
          m_lru[idx] = (way == 0);
        end
        pending = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the request completes.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output int nrd, output int nwr);
    cpu_rd_en   = rd;
    cpu_wr_en   = wr;
    cpu_address = a;
    cpu_wdata   = d;
    nrd   = 0;
    nwr   = 0;
    rdata = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nrd += int'(sram_rd_en);
      nwr += int'(sram_wr_en);
      if (cpu_ready) begin
        rdata = cpu_rdata;
        break;
      end
      if (i == 39) begin
        checks++;
        errors++;
        $display("FAIL timeout: cpu_ready still 0 after 40 cycles, addr %h", a);
      end
    end
    @(posedge clk);
    #1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    int nrd, nwr;

    rst            = 1'b1;
    cpu_rd_en      = 1'b0;
    cpu_wr_en      = 1'b0;
    cpu_address    = 32'd1024;
    cpu_wdata      = '0;
    sram_ready     = 1'b0;
    sram_read_data = '0;
    mem[1024] = 32'h1111_1111;
    mem[1028] = 32'h2222_2222;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_ready", cpu_ready, 1);
    check("reset_rdata", cpu_rdata, 0);
    check("reset_rd_en", sram_rd_en, 0);
    check("reset_wr_en", sram_wr_en, 0);

    // Miss then same-line hit.
    do_op(1, 0, 32'd1024, 0, rdata, nrd, nwr);
    check("miss_rdata", rdata, 32'h1111_1111);
    check("miss_rd_cycles", nrd, 6);
    do_op(1, 0, 32'd1028, 0, rdata, nrd, nwr);
    check("hit_rdata", rdata, 32'h2222_2222);
    check("hit_rd_cycles", nrd, 0);

    // LRU replacement in set 0.
    do_reset();
    do_op(1, 0, 32'd1024, 0, rdata, nrd, nwr);
    check("fill_w0", nrd, 6);
    do_op(1, 0, 32'd1536, 0, rdata, nrd, nwr);
    check("fill_w1", nrd, 6);
    do_op(1, 0, 32'd1024, 0, rdata, nrd, nwr);
    check("rehit_1024", nrd, 0);
    do_op(1, 0, 32'd2048, 0, rdata, nrd, nwr);
    check("fill_2048", nrd, 6);
    do_op(1, 0, 32'd1024, 0, rdata, nrd, nwr);
    check("kept_1024", nrd, 0);
    check("kept_1024_data", rdata, 32'h1111_1111);
    do_op(1, 0, 32'd1536, 0, rdata, nrd, nwr);
    check("evicted_1536", nrd, 6);

    // Store hit updates the cached word.
    do_op(0, 1, 32'd1028, 32'hDEAD_BEEF, rdata, nrd, nwr);
    check("store_wr_cycles", nwr, 6);
    check("store_rd_cycles", nrd, 0);
    do_op(1, 0, 32'd1028, 0, rdata, nrd, nwr);
    check("store_hit_data", rdata, 32'hDEAD_BEEF);
    check("store_hit_rd", nrd, 0);

    // Store miss does not allocate.
    do_op(0, 1, 32'd4096, 32'h1234_5678, rdata, nrd, nwr);
    check("wmiss_wr_cycles", nwr, 6);
    check("wmiss_rd_cycles", nrd, 0);
    do_op(1, 0, 32'd4096, 0, rdata, nrd, nwr);
    check("wmiss_read_rd", nrd, 6);
    check("wmiss_read_data", rdata, 32'h1234_5678);

    // Reset in the third fetch cycle aborts and invalidates.
    cpu_rd_en   = 1'b1;
    cpu_address = 32'd1064;
    repeat (4) @(negedge clk);
    check("pre_abort_rd_en", sram_rd_en, 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_rd_en", sram_rd_en, 0);
    cpu_rd_en = 1'b0;
    #1;
    check("abort_ready", cpu_ready, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(1, 0, 32'd1024, 0, rdata, nrd, nwr);
    check("post_reset_miss", nrd, 6);

    // Load and store together take the store path.
    do_op(1, 1, 32'd1024, 32'hA5A5_A5A5, rdata, nrd, nwr);
    check("both_rd_cycles", nrd, 0);
    check("both_wr_cycles", nwr, 6);
    do_op(1, 0, 32'd1024, 0, rdata, nrd, nwr);
    check("both_then_hit", nrd, 0);
    check("both_then_data", rdata, 32'hA5A5_A5A5);

    // Random traffic on a small address pool to exercise hits, conflicts and evictions.
    noise = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int op;
      a   = 32'd1024 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
            + ($urandom_range(0, 1) << 2);
      op  = $urandom_range(0, 9);
      lat = $urandom_range(1, 6);
      do_op(op < 6 || op == 9, op >= 6, a, $urandom, rdata, nrd, nwr);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
